alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: collects an A/B operand pair from a word stream, presents the
// registered operands and select to a combinational ALU, captures its result
// one cycle later and holds it until the downstream consumer takes it.
// A running count of consumed results wraps modulo 256.
module alu_seq_ctrl #(
  parameter int p_width = 6
) (
  input  logic                 i_w_clk,
  input  logic                 i_w_rst_n,
  input  logic [p_width:0]     i_w_data,
  input  logic                 i_w_valid,
  input  logic                 i_w_sel,
  output logic                 o_w_ready,
  input  logic                 i_w_clear,
  output logic [p_width:0]     o_w_a,
  output logic [p_width:0]     o_w_b,
  output logic                 o_w_sel,
  input  logic [2*p_width:0]   i_w_alu_out,
  output logic [2*p_width:0]   o_w_result,
  output logic                 o_w_result_valid,
  input  logic                 i_w_result_ready,
  output logic [7:0]           o_w_count
);

  typedef enum logic [1:0] {
    S_WAIT_A = 2'd0,
    S_WAIT_B = 2'd1,
    S_EXEC   = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Per-edge strobes; all forced low by clear so an abort never loads or counts.
  logic load_a;
  logic load_b;
  logic capture;
  logic consume;

  // Next-state, ready and transfer strobes; clear overrides every handshake.
  always_comb begin
    state_nxt = state;
    o_w_ready = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    capture   = 1'b0;
    consume   = 1'b0;
    case (state)
      S_WAIT_A: begin
        o_w_ready = 1'b1;
        if (i_w_valid) begin
          load_a    = 1'b1;
          state_nxt = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        o_w_ready = 1'b1;
        if (i_w_valid) begin
          load_b    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        capture   = 1'b1;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        if (i_w_result_ready) begin
          consume   = 1'b1;
          state_nxt = S_WAIT_A;
        end
      end
      default: state_nxt = S_WAIT_A;
    endcase
    if (i_w_clear) begin
      load_a    = 1'b0;
      load_b    = 1'b0;
      capture   = 1'b0;
      consume   = 1'b0;
      state_nxt = S_WAIT_A;
    end
  end

  // State register.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state <= S_WAIT_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand registers: written only on their own transfer, held otherwise.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      o_w_a   <= '0;
      o_w_b   <= '0;
      o_w_sel <= 1'b0;
    end else begin
      if (load_a) begin
        o_w_a <= i_w_data;
      end
      if (load_b) begin
        o_w_b   <= i_w_data;
        o_w_sel <= i_w_sel;
      end
    end
  end

  // Result capture and valid flag; the result word outlives its valid flag.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      o_w_result       <= '0;
      o_w_result_valid <= 1'b0;
    end else begin
      if (capture) begin
        o_w_result <= i_w_alu_out;
      end
      if (i_w_clear || consume) begin
        o_w_result_valid <= 1'b0;
      end else if (capture) begin
        o_w_result_valid <= 1'b1;
      end
    end
  end

  // Consumed-result counter, free-running wrap at 256.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      o_w_count <= 8'd0;
    end else if (consume) begin
      o_w_count <= o_w_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a signed add/multiply ALU sits on the operand
// outputs, and a transaction-level scoreboard tracks the expected operands,
// result and consumed count for every step.
module tb_alu_seq_ctrl;

  localparam int W = 6;

  logic            clk;
  logic            rst_n;
  logic [W:0]      data;
  logic            valid;
  logic            sel_in;
  logic            ready;
  logic            clear;
  logic [W:0]      o_a;
  logic [W:0]      o_b;
  logic            o_sel;
  logic [2*W:0]    alu_out;
  logic [2*W:0]    result;
  logic            result_valid;
  logic            result_ready;
  logic [7:0]      count;

  int tests;
  int fails;

  logic [W:0]      exp_a;
  logic [W:0]      exp_b;
  logic            exp_sel;
  logic [2*W:0]    exp_res;
  int              exp_count;

  alu_seq_ctrl #(.p_width(W)) dut (
    .i_w_clk          (clk),
    .i_w_rst_n        (rst_n),
    .i_w_data         (data),
    .i_w_valid        (valid),
    .i_w_sel          (sel_in),
    .o_w_ready        (ready),
    .i_w_clear        (clear),
    .o_w_a            (o_a),
    .o_w_b            (o_b),
    .o_w_sel          (o_sel),
    .i_w_alu_out      (alu_out),
    .o_w_result       (result),
    .o_w_result_valid (result_valid),
    .i_w_result_ready (result_ready),
    .o_w_count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed ALU: sel=0 sum, sel=1 product, both in 13-bit two's complement.
  function automatic logic [2*W:0] alu_f(input logic [W:0] a, input logic [W:0] b,
                                         input logic s);
    logic signed [2*W:0] ea;
    logic signed [2*W:0] eb;
    logic signed [2*W:0] r;
    ea = {{W{a[W]}}, a};
    eb = {{W{b[W]}}, b};
    if (s) r = ea * eb;
    else   r = ea + eb;
    return r;
  endfunction

  always_comb alu_out = alu_f(o_a, o_b, o_sel);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Transfer operand A; the word is applied for exactly one edge.
  task automatic send_a(input logic [W:0] a);
    check("ready_wait_a", 32'(ready), 32'd1);
    data = a; valid = 1'b1; sel_in = 1'($urandom);
    tick();
    valid = 1'b0; data = 7'($urandom);
    exp_a = a;
    check("a_loaded", 32'(o_a), 32'(exp_a));
    check("ready_wait_b", 32'(ready), 32'd1);
    check("rv_low_wait_b", 32'(result_valid), 32'd0);
  endtask

  // Idle cycles in S_WAIT_B with junk data and valid low.
  task automatic idle_b(input int gap);
    for (int g = 0; g < gap; g++) begin
      data = 7'($urandom); sel_in = 1'($urandom); valid = 1'b0;
      tick();
      check("b_hold_idle", 32'(o_b), 32'(exp_b));
      check("ready_idle_b", 32'(ready), 32'd1);
    end
  endtask

  // Transfer operand B with its select; next cycle is S_EXEC.
  task automatic send_b(input logic [W:0] b, input logic s);
    data = b; sel_in = s; valid = 1'b1;
    tick();
    valid = 1'b0; data = 7'($urandom); sel_in = 1'($urandom);
    exp_b = b; exp_sel = s;
    check("b_loaded", 32'(o_b), 32'(exp_b));
    check("sel_loaded", 32'(o_sel), 32'(exp_sel));
    check("ready_low_exec", 32'(ready), 32'd0);
    check("rv_low_after_b", 32'(result_valid), 32'd0);
  endtask

  // Closing edge of S_EXEC: result captured and flagged.
  task automatic exec_edge();
    tick();
    exp_res = alu_f(exp_a, exp_b, exp_sel);
    check("rv_high", 32'(result_valid), 32'd1);
    check("result", 32'(result), 32'(exp_res));
    check("ready_low_out", 32'(ready), 32'd0);
  endtask

  // Hold the result for 'stall' cycles with spurious valid, then consume it.
  task automatic drain(input int stall);
    result_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      valid = 1'($urandom); data = 7'($urandom);
      tick();
      check("rv_stall", 32'(result_valid), 32'd1);
      check("result_stall", 32'(result), 32'(exp_res));
      check("ready_stall", 32'(ready), 32'd0);
      check("count_stall", 32'(count), 32'(exp_count));
      check("a_stall", 32'(o_a), 32'(exp_a));
    end
    valid = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
    check("rv_consumed", 32'(result_valid), 32'd0);
    check("count", 32'(count), 32'(exp_count));
    check("ready_after_consume", 32'(ready), 32'd1);
    check("result_held", 32'(result), 32'(exp_res));
  endtask

  task automatic run_op(input logic [W:0] a, input logic [W:0] b, input logic s,
                        input int gap, input int stall);
    send_a(a);
    idle_b(gap);
    send_b(b, s);
    exec_edge();
    drain(stall);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; data = '0; valid = 1'b0; sel_in = 1'b0;
    clear = 1'b0; result_ready = 1'b0;
    exp_a = '0; exp_b = '0; exp_sel = 1'b0; exp_res = '0; exp_count = 0;

    // Reset values before any clock edge.
    #2;
    check("rst_a", 32'(o_a), 32'd0);
    check("rst_b", 32'(o_b), 32'd0);
    check("rst_sel", 32'(o_sel), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic pair, consumed immediately.
    run_op(7'd5, 7'd3, 1'b0, 0, 0);

    // Long stall in S_OUT with select 1.
    run_op(7'd12, 7'd7, 1'b1, 0, 5);

    // Valid dropping between A and B; B loads only on its valid cycle.
    run_op(7'd33, 7'd100, 1'b1, 1, 1);
    run_op(7'd127, 7'd64, 1'b0, 2, 0);

    // Clear together with result_ready in S_OUT.
    send_a(7'd9);
    send_b(7'd11, 1'b1);
    exec_edge();
    clear = 1'b1; result_ready = 1'b1;
    tick();
    clear = 1'b0; result_ready = 1'b0;
    check("clr_out_rv", 32'(result_valid), 32'd0);
    check("clr_out_count", 32'(count), 32'(exp_count));
    check("clr_out_ready", 32'(ready), 32'd1);
    check("clr_out_result", 32'(result), 32'(exp_res));

    // Clear with valid in S_WAIT_A: no load.
    clear = 1'b1; valid = 1'b1; data = 7'd77;
    tick();
    clear = 1'b0; valid = 1'b0;
    check("clr_wa_a", 32'(o_a), 32'(exp_a));
    check("clr_wa_ready", 32'(ready), 32'd1);

    // Clear with valid in S_WAIT_B: B untouched, back to S_WAIT_A.
    send_a(7'd21);
    clear = 1'b1; valid = 1'b1; data = 7'd55; sel_in = ~exp_sel;
    tick();
    clear = 1'b0; valid = 1'b0;
    check("clr_wb_b", 32'(o_b), 32'(exp_b));
    check("clr_wb_sel", 32'(o_sel), 32'(exp_sel));
    check("clr_wb_ready", 32'(ready), 32'd1);
    run_op(7'd40, 7'd2, 1'b1, 0, 0);

    // Asynchronous reset pulse between edges while in S_EXEC.
    send_a(7'd17);
    send_b(7'd19, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_a", 32'(o_a), 32'd0);
    check("arst_b", 32'(o_b), 32'd0);
    check("arst_sel", 32'(o_sel), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_rv", 32'(result_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_ready", 32'(ready), 32'd1);
    #1 rst_n = 1'b1;
    exp_a = '0; exp_b = '0; exp_sel = 1'b0; exp_res = '0; exp_count = 0;
    @(negedge clk);
    run_op(7'd6, 7'd7, 1'b1, 0, 0);

    // Randomized operations.
    for (int i = 0; i < 20; i++) begin
      run_op(7'($urandom), 7'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    // 256 back-to-back operations: counter wraps back to its start value.
    begin
      int start_count;
      start_count = exp_count;
      for (int i = 0; i < 256; i++) begin
        run_op(7'($urandom), 7'($urandom), 1'($urandom), 0, 0);
      end
      check("wrap_count", 32'(count), 32'(start_count));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
